alu_arbiter: RTL and testbench

Round-robin arbiter that shares the single-cycle ALU between two requesters, e.g. the main datapath and a debug/self-test port. It accepts one operation at a time through a valid/ready handshake, drives registered operands onto the external ALU for one cycle, and captures the result and NZCV flags into a response register. The response is held until the consumer accepts it. The ALU itself stays purely combinational and sits outside this block.

---
 rtl/alu_arbiter.sv | 142 ++++++++++++++
 tb/tb_alu_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Round-robin grant, one operation in flight, and a response register
// that holds result/flags/tag until the consumer takes them.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_ctrl,
    input  logic             req0_carry,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [TAG_W-1:0] req0_tag,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_ctrl,
    input  logic             req1_carry,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [TAG_W-1:0] req1_tag,

    output logic [WIDTH-1:0] alu_srca,
    output logic [WIDTH-1:0] alu_srcb,
    output logic [3:0]       alu_ctrl,
    output logic             alu_carry,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;

    // Operand registers feeding the ALU during EXEC
    logic [3:0]       ctrl_p1;
    logic             carry_p1;
    logic [WIDTH-1:0] a_p1;
    logic [WIDTH-1:0] b_p1;

    logic             grant;
    logic             open;
    logic             accept;
    logic [3:0]       sel_ctrl;
    logic             sel_carry;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [TAG_W-1:0] sel_tag;

    // Grant: a lone requester always wins; a tie goes to the port that lost last time
    always_comb begin
        grant = req1_valid;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end
        open       = (state == IDLE) || ((state == RESP) && rsp_ready);
        accept     = open && (req0_valid || req1_valid);
        req0_ready = open && !grant;
        req1_ready = open && grant;
        sel_ctrl   = grant ? req1_ctrl  : req0_ctrl;
        sel_carry  = grant ? req1_carry : req0_carry;
        sel_a      = grant ? req1_a     : req0_a;
        sel_b      = grant ? req1_b     : req0_b;
        sel_tag    = grant ? req1_tag   : req0_tag;
    end

    // The ALU sees the operand registers at all times; only EXEC uses the answer
    assign alu_ctrl  = ctrl_p1;
    assign alu_carry = carry_p1;
    assign alu_srca  = a_p1;
    assign alu_srcb  = b_p1;

    // Control FSM plus operand/response capture; reset drops any in-flight op
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            rsp_valid  <= 1'b0;
            last_grant <= 1'b1;
            ctrl_p1    <= '0;
            carry_p1   <= 1'b0;
            a_p1       <= '0;
            b_p1       <= '0;
            rsp_id     <= 1'b0;
            rsp_tag    <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_flags  <= alu_flags;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= accept ? EXEC : IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase

            // accept is only possible in IDLE or in RESP while the response drains,
            // so rsp_id/rsp_tag never change under a held response
            if (accept) begin
                ctrl_p1    <= sel_ctrl;
                carry_p1   <= sel_carry;
                a_p1       <= sel_a;
                b_p1       <= sel_b;
                rsp_id     <= grant;
                rsp_tag    <= sel_tag;
                last_grant <= grant;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a reference ALU on the external ALU port, queue-fed
// requesters, a transaction-level arbitration model checked every cycle, and
// directed scenarios with hand-computed expectations.
module tb_alu_arbiter;

    localparam int WIDTH = 32;
    localparam int TAG_W = 4;

    logic             clk;
    logic             reset;
    logic             req0_valid, req0_ready, req0_carry;
    logic [3:0]       req0_ctrl;
    logic [WIDTH-1:0] req0_a, req0_b;
    logic [TAG_W-1:0] req0_tag;
    logic             req1_valid, req1_ready, req1_carry;
    logic [3:0]       req1_ctrl;
    logic [WIDTH-1:0] req1_a, req1_b;
    logic [TAG_W-1:0] req1_tag;
    logic [WIDTH-1:0] alu_srca, alu_srcb, alu_result;
    logic [3:0]       alu_ctrl, alu_flags;
    logic             alu_carry;
    logic             rsp_valid, rsp_ready, rsp_id;
    logic [TAG_W-1:0] rsp_tag;
    logic [WIDTH-1:0] rsp_result;
    logic [3:0]       rsp_flags;

    alu_arbiter #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
        .req0_carry(req0_carry), .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
        .req1_carry(req1_carry), .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_ctrl(alu_ctrl), .alu_carry(alu_carry),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags)
    );

    typedef struct {
        logic [3:0]       ctrl;
        logic             carry;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [TAG_W-1:0] tag;
    } op_t;

    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    op_t  q0[$];
    op_t  q1[$];
    int   log_port[$];
    int   log_cyc[$];
    logic acc0_s, acc1_s;

    // model state
    logic             m_init, m_exec, m_rsp, m_id;
    int               m_last;
    logic [TAG_W-1:0] m_tag;
    logic [WIDTH-1:0] m_res, m_a, m_b;
    logic [3:0]       m_flg, m_ctrl;
    logic             m_carry;

    // reference ALU: returns {N,Z,C,V, result}
    function automatic logic [35:0] alu_ref(input logic [3:0] c, input logic cin,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic        cf, vf;
        cf = 1'b0;
        vf = 1'b0;
        s  = '0;
        case (c)
            4'h0: begin
                s  = {1'b0, a} + {1'b0, b} + {32'd0, cin};
                r  = s[31:0];
                cf = s[32];
                vf = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'h1: begin
                s  = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r  = s[31:0];
                cf = s[32];
                vf = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'h2:    r = a & b;
            4'h3:    r = a | b;
            default: r = a ^ b;
        endcase
        return {r[31], (r == 32'd0), cf, vf, r};
    endfunction

    always_comb begin
        {alu_flags, alu_result} = alu_ref(alu_ctrl, alu_carry, alu_srca, alu_srcb);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t cyc=%0d)", name, act, exp, $time, cyc);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // requester 0: present queue head, pop when handshake completed
    initial begin
        req0_valid = 1'b0; req0_ctrl = '0; req0_carry = 1'b0;
        req0_a = '0; req0_b = '0; req0_tag = '0;
        forever begin
            @(posedge clk); #1;
            if (acc0_s && q0.size() > 0) void'(q0.pop_front());
            if (q0.size() > 0) begin
                req0_valid = 1'b1; req0_ctrl = q0[0].ctrl; req0_carry = q0[0].carry;
                req0_a = q0[0].a; req0_b = q0[0].b; req0_tag = q0[0].tag;
            end else begin
                req0_valid = 1'b0;
            end
        end
    end

    // requester 1
    initial begin
        req1_valid = 1'b0; req1_ctrl = '0; req1_carry = 1'b0;
        req1_a = '0; req1_b = '0; req1_tag = '0;
        forever begin
            @(posedge clk); #1;
            if (acc1_s && q1.size() > 0) void'(q1.pop_front());
            if (q1.size() > 0) begin
                req1_valid = 1'b1; req1_ctrl = q1[0].ctrl; req1_carry = q1[0].carry;
                req1_a = q1[0].a; req1_b = q1[0].b; req1_tag = q1[0].tag;
            end else begin
                req1_valid = 1'b0;
            end
        end
    end

    // transaction model: compare at mid-cycle, then predict the next edge
    initial begin
        logic        free;
        int          win;
        logic [35:0] r;
        m_init = 1'b0; m_exec = 1'b0; m_rsp = 1'b0; m_last = 1;
        acc0_s = 1'b0; acc1_s = 1'b0;
        forever begin
            @(negedge clk);
            if (m_init) begin
                chk("rsp_valid", rsp_valid, m_rsp);
                chk("rsp_id", rsp_id, m_id);
                chk("rsp_tag", rsp_tag, m_tag);
                chk("rsp_result", rsp_result, m_res);
                chk("rsp_flags", rsp_flags, m_flg);
                chk("alu_srca", alu_srca, m_a);
                chk("alu_srcb", alu_srcb, m_b);
                chk("alu_ctrl", alu_ctrl, m_ctrl);
                chk("alu_carry", alu_carry, m_carry);
            end
            if (!reset) begin
                m_init = 1'b1; m_exec = 1'b0; m_rsp = 1'b0; m_last = 1;
                m_id = 1'b0; m_tag = '0; m_res = '0; m_flg = '0;
                m_a = '0; m_b = '0; m_ctrl = '0; m_carry = 1'b0;
                acc0_s = 1'b0; acc1_s = 1'b0;
            end else if (m_init) begin
                free = !m_exec && (!m_rsp || rsp_ready);
                win  = -1;
                if (free) begin
                    if (req0_valid && req1_valid) win = 1 - m_last;
                    else if (req0_valid)          win = 0;
                    else if (req1_valid)          win = 1;
                end
                if (!free) begin
                    chk("req0_ready_closed", req0_ready, 1'b0);
                    chk("req1_ready_closed", req1_ready, 1'b0);
                end else if (win >= 0) begin
                    chk("req0_ready", req0_ready, win == 0);
                    chk("req1_ready", req1_ready, win == 1);
                end
                acc0_s = req0_valid && req0_ready;
                acc1_s = req1_valid && req1_ready;
                if (m_exec) begin
                    r = alu_ref(m_ctrl, m_carry, m_a, m_b);
                    m_res = r[31:0];
                    m_flg = r[35:32];
                    m_rsp = 1'b1;
                end else if (m_rsp && rsp_ready) begin
                    m_rsp = 1'b0;
                end
                m_exec = (win >= 0);
                if (win == 0) begin
                    m_ctrl = req0_ctrl; m_carry = req0_carry; m_a = req0_a; m_b = req0_b;
                    m_id = 1'b0; m_tag = req0_tag;
                end else if (win == 1) begin
                    m_ctrl = req1_ctrl; m_carry = req1_carry; m_a = req1_a; m_b = req1_b;
                    m_id = 1'b1; m_tag = req1_tag;
                end
                if (win >= 0) begin
                    m_last = win;
                    log_port.push_back(win);
                    log_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk); #2;
        end
    endtask

    function automatic op_t mk(input logic [3:0] c, input logic cin, input logic [31:0] a,
                               input logic [31:0] b, input logic [3:0] t);
        op_t o;
        o.ctrl = c; o.carry = cin; o.a = a; o.b = b; o.tag = t;
        return o;
    endfunction

    task automatic wait_idle(input string name, input int limit, input logic rnd_ready);
        int t = 0;
        while ((q0.size() != 0 || q1.size() != 0 || m_exec || m_rsp) && t < limit) begin
            if (rnd_ready) rsp_ready = 1'($urandom_range(0, 1));
            step(1);
            t++;
        end
        rsp_ready = 1'b1;
        while ((m_exec || m_rsp) && t < limit) begin
            step(1);
            t++;
        end
        chk({name, "_done_in_time"}, (t < limit), 1'b1);
    endtask

    task automatic wait_rsp(input string name, input int limit);
        int t = 0;
        while (!rsp_valid && t < limit) begin
            step(1);
            t++;
        end
        chk({name, "_rsp_in_time"}, (t < limit), 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] cap_res;
        logic [3:0]       cap_flg;
        logic [TAG_W-1:0] cap_tag;
        logic             cap_id;
        int               c0;

        reset = 1'b0;
        rsp_ready = 1'b0;

        // pin the reference ALU with hand-derived values
        chk("ref_add_wrap", alu_ref(4'h0, 1'b0, 32'h1, 32'hFFFF_FFFF), {4'b0110, 32'h0});
        chk("ref_sub_eq", alu_ref(4'h1, 1'b0, 32'h5, 32'h5), {4'b0110, 32'h0});
        chk("ref_add_ovf", alu_ref(4'h0, 1'b0, 32'h7FFF_FFFF, 32'h1), {4'b1001, 32'h8000_0000});
        chk("ref_add_cin", alu_ref(4'h0, 1'b1, 32'h2, 32'h3), {4'b0000, 32'h6});

        step(3);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_alu_srca", alu_srca, 32'h0);
        chk("reset_rsp_result", rsp_result, 32'h0);
        reset = 1'b1;
        step(1);

        // contention: alternate grants, one accept every 2 cycles
        rsp_ready = 1'b1;
        log_port.delete(); log_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(4'h0, 1'b0, 32'(i), 32'(100 + i), 4'(i)));
            q1.push_back(mk(4'h1, 1'b0, 32'(50 + i), 32'(i), 4'(8 + i)));
        end
        wait_idle("contention", 100, 1'b0);
        chk("contention_count", log_port.size(), 8);
        for (int i = 0; i < log_port.size() && i < 8; i++) begin
            chk("contention_order", log_port[i], i % 2);
            if (i > 0) chk("contention_spacing", log_cyc[i] - log_cyc[i-1], 2);
        end

        // single request: ADD 1 + 0xFFFFFFFF
        rsp_ready = 1'b0;
        step(1);
        log_port.delete(); log_cyc.delete();
        q0.push_back(mk(4'b0000, 1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 4'h3));
        wait_rsp("single", 20);
        chk("single_latency", (log_cyc.size() > 0) ? cyc - log_cyc[0] : -1, 2);
        chk("single_result", rsp_result, 32'h0000_0000);
        chk("single_flags", rsp_flags, 4'b0110);
        chk("single_id", rsp_id, 1'b0);
        chk("single_tag", rsp_tag, 4'h3);
        rsp_ready = 1'b1;
        wait_idle("single", 20, 1'b0);

        // lone requester after winning is not blocked by last_grant
        log_port.delete(); log_cyc.delete();
        c0 = cyc;
        q0.push_back(mk(4'h2, 1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 4'h5));
        wait_idle("lone", 20, 1'b0);
        chk("lone_count", log_port.size(), 1);
        chk("lone_port", (log_port.size() > 0) ? log_port[0] : -1, 0);
        chk("lone_immediate", (log_cyc.size() > 0) ? log_cyc[0] - c0 : -1, 1);

        // backpressure: response held 5 cycles while port1 waits
        rsp_ready = 1'b0;
        log_port.delete(); log_cyc.delete();
        q0.push_back(mk(4'h3, 1'b1, 32'h1234_0000, 32'h0000_5678, 4'hA));
        wait_rsp("bp", 20);
        q1.push_back(mk(4'h0, 1'b1, 32'hFFFF_FFFF, 32'h0, 4'hB));
        cap_res = rsp_result; cap_flg = rsp_flags; cap_tag = rsp_tag; cap_id = rsp_id;
        chk("bp_result", cap_res, 32'h1234_5678);
        for (int k = 0; k < 5; k++) begin
            step(1);
            chk("bp_hold_valid", rsp_valid, 1'b1);
            chk("bp_hold_result", rsp_result, cap_res);
            chk("bp_hold_flags", rsp_flags, cap_flg);
            chk("bp_hold_tag", rsp_tag, cap_tag);
            chk("bp_hold_id", rsp_id, cap_id);
            chk("bp_req0_ready", req0_ready, 1'b0);
            chk("bp_req1_ready", req1_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_req1_ready", req1_ready, 1'b1);
        step(1);
        chk("bp_release_accept", log_port.size(), 2);
        chk("bp_release_port", (log_port.size() > 1) ? log_port[1] : -1, 1);
        chk("bp_release_cycle", (log_cyc.size() > 1) ? cyc - log_cyc[1] : -1, 1);
        wait_idle("bp", 20, 1'b0);
        chk("bp_second_result", rsp_result, 32'h0000_0000);
        chk("bp_second_flags", rsp_flags, 4'b0110);

        // reset during EXEC drops the operation
        log_port.delete(); log_cyc.delete();
        q0.push_back(mk(4'h0, 1'b0, 32'h1234_5678, 32'h1, 4'h7));
        step(2);
        chk("rst_op_accepted", log_port.size(), 1);
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_alu_srca", alu_srca, 32'h0);
        step(3);
        chk("rst_no_response", rsp_valid, 1'b0);
        log_port.delete(); log_cyc.delete();
        q0.push_back(mk(4'h4, 1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 4'h1));
        q1.push_back(mk(4'h4, 1'b0, 32'hFFFF_0000, 32'hFFFF_0000, 4'h2));
        wait_idle("rst_tie", 20, 1'b0);
        chk("rst_tie_first", (log_port.size() > 0) ? log_port[0] : -1, 0);
        chk("rst_tie_second", (log_port.size() > 1) ? log_port[1] : -1, 1);

        // pass-through: corner and random operands on both ports
        q0.push_back(mk(4'h0, 1'b0, 32'h7FFF_FFFF, 32'h1, 4'h0));
        q1.push_back(mk(4'h1, 1'b0, 32'h0, 32'h1, 4'hF));
        q0.push_back(mk(4'h1, 1'b0, 32'h8000_0000, 32'h1, 4'h9));
        q1.push_back(mk(4'h0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h6));
        for (int i = 0; i < 12; i++) begin
            q0.push_back(mk(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                            $urandom, $urandom, 4'($urandom_range(0, 15))));
            q1.push_back(mk(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                            $urandom, $urandom, 4'($urandom_range(0, 15))));
        end
        wait_idle("passthru", 1000, 1'b1);

        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
